// File: rtl/act_skew_feeder.sv
// act_skew_feeder: FIFO-buffered activation feeder that skews lane i by i cycles and drains zeros after each tile.
// Optional bubble counter output enabled by defining FEEDER_BUBBLE_CNT_EN.
module act_skew_feeder #(
    parameter int num1   = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   EN,
    input  logic [num1*DATA_W-1:0] in_vec,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [num1*DATA_W-1:0] active_left,
    output logic                   busy,
    output logic                   done
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]            bubble_cnt
`endif
);
    localparam int W  = num1 * DATA_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (num1 > 1) ? $clog2(num1) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t         r_state, w_state_n;
    logic [W:0]     r_mem [DEPTH];
    logic [AW:0]    r_wp, r_rp;
    logic [CW-1:0]  r_cnt;
    logic [W:0]     w_head;
    logic           w_empty, w_full, w_push, w_pop, w_cnt_end;

    assign w_empty   = r_wp == r_rp;
    assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push    = in_valid && !w_full;
    assign w_head    = r_mem[r_rp[AW-1:0]];
    assign w_cnt_end = r_cnt == CW'(num1 - 1);
    assign in_ready  = !w_full;
    assign busy      = r_state != IDLE;
    assign done      = (r_state == DRAIN) && w_cnt_end;

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= {in_last, in_vec};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (EN) begin
            r_state <= w_state_n;
            r_cnt   <= (r_state == DRAIN && !w_cnt_end) ? r_cnt + 1'b1 : '0;
        end
    end

    // The final drain cycle may already pop the next tile so tiles run back to back.
    always_comb begin
        w_state_n = r_state;
        w_pop     = 1'b0;
        case (r_state)
            IDLE, STREAM: if (EN && !w_empty) begin
                w_pop     = 1'b1;
                w_state_n = w_head[W] ? DRAIN : STREAM;
            end
            DRAIN: if (EN && w_cnt_end) begin
                w_pop     = !w_empty;
                w_state_n = w_empty ? IDLE : (w_head[W] ? DRAIN : STREAM);
            end
            default: w_state_n = IDLE;
        endcase
    end

    for (genvar g = 0; g < num1; g++) begin : g_lane
        logic [DATA_W-1:0] r_d [g+1];
        logic [g:0]        r_v;
        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_v <= '0;
                for (int j = 0; j <= g; j++) r_d[j] <= '0;
            end else if (EN) begin
                r_v[0] <= w_pop;
                r_d[0] <= w_head[g*DATA_W +: DATA_W];
                for (int j = 1; j <= g; j++) begin
                    r_v[j] <= r_v[j-1];
                    r_d[j] <= r_d[j-1];
                end
            end
        end
        assign active_left[g*DATA_W +: DATA_W] = r_v[g] ? r_d[g] : '0;
    end

`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] r_bub;
    always_ff @(posedge CLK) begin
        if (RESET) r_bub <= '0;
        else if (EN) begin
            if (r_state == IDLE && w_pop) r_bub <= '0;
            else if (r_state == STREAM && w_empty && r_bub != 16'hFFFF) r_bub <= r_bub + 1'b1;
        end
    end
    assign bubble_cnt = r_bub;
`endif
endmodule

// File: doc/act_skew_feeder.md
Name: act_skew_feeder

Overview:
- Sits directly upstream of PE_array and drives its active_left bus.
- Accepts one activation vector per transfer (one 8-bit element per array row) through a valid/ready handshake and buffers the vectors in a small FIFO.
- Emits each vector diagonally skewed: lane i is delayed i cycles, giving the wavefront a weight-stationary systolic array needs.
- Flushes zeros after the last vector of a tile so partial sums drain, then pulses done.

Parameters:
- num1, 2, number of array rows = number of active_left lanes (>=1)
- DATA_W, 8, element width per lane
- DEPTH, 4, input FIFO depth in vectors (power of 2, >=2)

Ports:
- CLK  input  1  clock, rising edge
- RESET  input  1  synchronous, active-high reset
- EN  input  1  global enable; low freezes the skew/drain datapath
- in_vec  input  num1*DATA_W  activation vector; lane i at bits [i*DATA_W +: DATA_W]
- in_last  input  1  qualifies in_vec as the final vector of the tile
- in_valid  input  1  producer has a vector
- in_ready  output  1  FIFO can accept (= !full)
- active_left  output  num1*DATA_W  skewed activations to PE_array
- busy  output  1  tile in flight
- done  output  1  one-cycle pulse when the last element leaves lane num1-1

Behaviour:
- Decided interface: one clock (CLK). Reset (RESET) is synchronous and active-high.
- Reset clears FIFO, delay lines, state and counter. Outputs after reset: active_left=0, busy=0, done=0, in_ready=1. Reset mid-tile discards all buffered and in-flight data; no done pulse.
- Push: occurs when in_valid && in_ready. The vector and in_last are stored.
- Full FIFO: in_ready=0. A push in the same cycle as a pop is not accepted (no push-through).
- The push path is independent of EN.
- FSM states IDLE, STREAM, DRAIN:
  - IDLE: on EN && FIFO non-empty, pop and go to STREAM. busy rises the cycle after the pop.
  - STREAM: on each EN cycle, pop if non-empty. Popping a vector with in_last=1 goes to DRAIN.
  - STREAM, FIFO empty with EN high: a bubble (valid=0) enters the skew, lane outputs read 0, state holds.
  - DRAIN: no pops. Count num1 EN cycles, then return to IDLE. done=1 exactly in the cycle lane num1-1 presents the last element.
  - done is followed by busy=0 in the next cycle, unless a new pop happened in the done cycle.
  - A pop is allowed in the done cycle, so back-to-back tiles are possible.
- Skew datapath: lane i holds a (data, valid) shift chain of depth i+1. Registered output is data when valid, else 0.
- Latency: a vector popped at edge k appears on lane i during cycle k+1+i.
- EN low: no pop, no shift, no DRAIN count. active_left, busy and done hold their values.
  - A done cycle held by EN low stays asserted until the next EN-high edge; the pulse is one EN-cycle wide.
- num1=1: no skew; done coincides with the lane-0 output of the last element.
- No arithmetic; widths pass through unchanged.

Optional Feature:
- Macro FEEDER_BUBBLE_CNT_EN.
- Defined:
  - Adds output bubble_cnt[15:0]: counts STREAM cycles with EN=1 and FIFO empty.
  - Saturates at 16'hFFFF.
  - Cleared by RESET and on the IDLE->STREAM pop.
  - Holds its value after done.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Basic skew (num1=2): push (lane1,lane0)=(3,1), then (4,2) with in_last; EN=1. First pop at edge k.
  - lane0 = 1 @k+1, 2 @k+2, 0 after.
  - lane1 = 0 @k+1, 3 @k+2, 4 @k+3.
  - done=1 only @k+3; busy high k+1..k+3.
- Bubble: push (3,1); wait 2 cycles; push (4,2) last.
  - lane0 = 1, 0, 0, 2.
  - lane1 shows the same pattern delayed 1 cycle.
  - bubble_cnt=2 when the macro is defined.
- Backpressure (DEPTH=4): hold EN=0 and push 5 vectors.
  - in_ready drops after the 4th push; the 5th is held by the producer.
  - Raise EN: order is preserved and the 5th vector is accepted the cycle after the first pop.
- EN freeze: drop EN for 3 cycles mid-STREAM.
  - active_left is frozen for those cycles; no FIFO pop.
  - On resume the sequence continues with no lost or duplicated elements.
- Reset mid-tile: assert RESET during DRAIN.
  - Next cycle: active_left=0, busy=0, done stays 0, in_ready=1.
  - A fresh tile afterwards behaves as in the basic skew scenario.
- Back-to-back tiles: tile B is pushed before tile A's done.
  - B's first element appears on lane0 the cycle after A's done.
  - One done pulse per tile.
